imem_boot_ctrl: RTL and testbench

//  Owns the single write/read port of the instruction memory and shares it

---
 rtl/imem_boot_ctrl.sv | 131 +++++++++++++
 tb/tb_imem_boot_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory port owner: shares the single imem port between the
// fetch stage and a boot/debug loader stream, sequencing load sessions.
module imem_boot_ctrl #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned FLUSH_CYC = 2,
    parameter bit          BOOT_HOLD = 1'b0,
    parameter logic [31:0] NOP_WORD  = 32'hE1A00000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_count,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    input  logic [31:0]       pc_f,
    output logic [31:0]       instr_f,
    output logic              stall_f,
    output logic              cpu_reset,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd,
    output logic              busy,
    output logic              done,
    output logic              oob_err
);

    localparam int unsigned   FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_LOAD, S_FLUSH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              done_q, done_d;
    logic              oob_err_q, oob_err_d;

    logic              pc_oob;
    logic [ADDR_W:0]   count_clamped;
    logic              unused_pc_lsb;

    // Byte offset within a word carries no meaning for a word-wide imem.
    assign unused_pc_lsb = ^pc_f[1:0];
    assign pc_oob        = |pc_f[31:ADDR_W+2];
    assign count_clamped = (ld_count > DEPTH) ? DEPTH : ld_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            if (BOOT_HOLD) state_q <= S_HOLD;
            else           state_q <= S_RUN;
            wr_ptr_q    <= '0;
            remaining_q <= '0;
            flush_cnt_q <= '0;
            done_q      <= 1'b0;
            oob_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            remaining_q <= remaining_d;
            flush_cnt_q <= flush_cnt_d;
            done_q      <= done_d;
            oob_err_q   <= oob_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        remaining_d = remaining_q;
        flush_cnt_d = flush_cnt_q;
        oob_err_d   = oob_err_q;
        ld_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wd      = '0;
        instr_f     = NOP_WORD;
        stall_f     = 1'b1;
        cpu_reset   = 1'b1;
        busy        = 1'b1;

        unique case (state_q)
            S_HOLD, S_RUN: begin
                if (state_q == S_RUN) begin
                    cpu_reset = 1'b0;
                    stall_f   = 1'b0;
                    busy      = 1'b0;
                    mem_addr  = pc_f[ADDR_W+1:2];
                    instr_f   = pc_oob ? NOP_WORD : mem_rd;
                    oob_err_d = oob_err_q | pc_oob;
                end
                if (ld_start) begin
                    wr_ptr_d    = ld_base;
                    remaining_d = count_clamped;
                    flush_cnt_d = '0;
                    // A zero-length session is just a core re-reset.
                    state_d     = (ld_count == '0) ? S_FLUSH : S_LOAD;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                mem_addr = wr_ptr_q;
                mem_wd   = ld_data;
                mem_we   = ld_valid;
                if (ld_valid) begin
                    wr_ptr_d    = wr_ptr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == 1) begin
                        flush_cnt_d = '0;
                        state_d     = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FC_LAST) state_d = S_RUN;
                else                        flush_cnt_d = flush_cnt_q + 1'b1;
            end
            default: state_d = state_q;
        endcase

        done_d = (state_q == S_FLUSH) && (state_d == S_RUN);
    end

    assign done    = done_q;
    assign oob_err = oob_err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: random load sessions and fetches
// checked against an abstract model of imem contents and session timing.
module tb_imem_boot_ctrl;

    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned DEPTH     = 64;
    localparam int unsigned FLUSH_CYC = 2;
    localparam logic [31:0] NOP       = 32'hE1A00000;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic [ADDR_W:0]   ld_count;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_ready;
    logic [31:0]       pc_f;
    logic [31:0]       instr_f;
    logic              stall_f;
    logic              cpu_reset;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;
    logic              busy;
    logic              done;
    logic              oob_err;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    bit mem_inited = 1'b0;
    logic [31:0] tb_mem  [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] data_q [$];
    logic        exp_oob;

    imem_boot_ctrl #(
        .ADDR_W(ADDR_W), .FLUSH_CYC(FLUSH_CYC), .BOOT_HOLD(1'b1), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .reset(reset), .ld_start(ld_start), .ld_base(ld_base),
        .ld_count(ld_count), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .pc_f(pc_f), .instr_f(instr_f), .stall_f(stall_f),
        .cpu_reset(cpu_reset), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy), .done(done),
        .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE0000 + 32'(i * 13);
    endfunction

    // Behavioural imem: combinational read, write on rising edge.
    assign mem_rd = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_val(i);
            mem_inited = 1'b1;
        end else if (mem_we) begin
            tb_mem[mem_addr] <= mem_wd;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int a, input logic [31:0] exp);
        pc_f     = {24'd0, a[5:0], 2'($urandom_range(3))};
        ld_valid = 1'($urandom_range(1));
        #1;
        chk("fetch_instr", instr_f, exp);
        chk("fetch_no_we", mem_we, 1'b0);
        chk("fetch_stall", stall_f, 1'b0);
        chk("fetch_oob", oob_err, exp_oob);
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic random_fetches(input int n);
        for (int j = 0; j < n; j++) begin
            int a;
            a = $urandom_range(DEPTH - 1);
            fetch(a, ref_mem[a]);
        end
    endtask

    // vmode: 0 back-to-back, 1 fixed gap pattern 1,0,1,1,0,1 with stray
    // ld_start pulses, 2 random gaps.
    task automatic do_load(input int base, input int count, input int vmode);
        int n, i, k, w0, a;
        logic v;
        logic [5:0] pat;
        pat = 6'b101101;
        ld_start = 1'b1;
        ld_base  = base[ADDR_W-1:0];
        ld_count = count[ADDR_W:0];
        ld_valid = 1'b0;
        #1;
        chk("start_no_we", mem_we, 1'b0);
        tick();
        ld_start = 1'b0;
        n  = (count > DEPTH) ? DEPTH : count;
        w0 = wr_cnt;
        i  = 0;
        k  = 0;
        while (i < n && k < 300) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? pat[k % 6] : ($urandom_range(3) != 0);
            ld_valid = v;
            ld_data  = (v && data_q.size() > 0) ? data_q.pop_front() : $urandom;
            ld_start = (vmode == 1) && !v;
            ld_base  = ADDR_W'($urandom);
            ld_count = 7'($urandom);
            #1;
            chk("load_ready", ld_ready, 1'b1);
            chk("load_cpu_reset", cpu_reset, 1'b1);
            chk("load_instr_nop", instr_f, NOP);
            chk("load_we", mem_we, v);
            if (v) begin
                a = (base + i) % DEPTH;
                chk("load_addr", mem_addr, a);
                chk("load_wd", mem_wd, ld_data);
                ref_mem[a] = ld_data;
                i++;
            end
            tick();
            k++;
        end
        ld_valid = 1'b0;
        ld_start = 1'b0;
        chk("load_words_accepted", i, n);
        chk("write_count", wr_cnt - w0, n);
        for (int f = 0; f < FLUSH_CYC; f++) begin
            ld_start = (vmode == 1);
            ld_base  = ADDR_W'($urandom);
            ld_count = 7'($urandom_range(1, 127));
            ld_valid = 1'($urandom_range(1));
            #1;
            chk("flush_cpu_reset", cpu_reset, 1'b1);
            chk("flush_ready", ld_ready, 1'b0);
            chk("flush_no_we", mem_we, 1'b0);
            chk("flush_done", done, 1'b0);
            chk("flush_busy", busy, 1'b1);
            tick();
        end
        ld_start = 1'b0;
        ld_valid = 1'b0;
        a = $urandom_range(DEPTH - 1);
        pc_f = {24'd0, a[5:0], 2'b00};
        #1;
        chk("run_busy", busy, 1'b0);
        chk("run_cpu_reset", cpu_reset, 1'b0);
        chk("run_done", done, 1'b1);
        chk("run_first_fetch", instr_f, ref_mem[a]);
        tick();
        chk("done_single", done, 1'b0);
    endtask

    initial begin
        reset = 1'b1; ld_start = 1'b0; ld_base = '0; ld_count = '0;
        ld_valid = 1'b0; ld_data = '0; pc_f = '0; exp_oob = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Boot hold: core frozen, loader ignored.
        for (int c = 0; c < 10; c++) begin
            ld_valid = 1'($urandom_range(1));
            ld_data  = $urandom;
            pc_f     = $urandom;
            #1;
            chk("hold_cpu_reset", cpu_reset, 1'b1);
            chk("hold_stall", stall_f, 1'b1);
            chk("hold_instr", instr_f, NOP);
            chk("hold_no_we", mem_we, 1'b0);
            chk("hold_ready", ld_ready, 1'b0);
            chk("hold_busy", busy, 1'b1);
            chk("hold_done", done, 1'b0);
            chk("hold_oob", oob_err, 1'b0);
            tick();
        end
        ld_valid = 1'b0;

        data_q = '{32'hE04F000F, 32'hE2801004, 32'hE2812008};
        do_load(0, 3, 0);
        fetch(1, 32'hE2801004);
        fetch(0, 32'hE04F000F);
        fetch(2, 32'hE2812008);

        do_load($urandom_range(DEPTH - 1), 4, 1);
        random_fetches(6);

        do_load(62, 4, 0);
        fetch(62, ref_mem[62]);
        fetch(1, ref_mem[1]);
        do_load($urandom_range(DEPTH - 1), 127, 2);
        random_fetches(8);

        // Out-of-range fetch.
        pc_f = 32'h0000_0100;
        #1;
        chk("oob_instr", instr_f, NOP);
        chk("oob_not_yet", oob_err, 1'b0);
        tick();
        chk("oob_set", oob_err, 1'b1);
        exp_oob = 1'b1;
        for (int j = 0; j < 4; j++) begin
            pc_f = $urandom | 32'h0000_0100;
            #1;
            chk("oob_rand_instr", instr_f, NOP);
            tick();
        end
        random_fetches(4);
        do_load($urandom_range(DEPTH - 1), $urandom_range(1, 8), 2);
        chk("oob_sticky", oob_err, 1'b1);

        // Reset in the middle of a session.
        ld_start = 1'b1; ld_base = 6'd10; ld_count = 7'd5;
        tick();
        ld_start = 1'b0;
        for (int j = 0; j < 2; j++) begin
            ld_valid = 1'b1;
            ld_data  = $urandom;
            #1;
            chk("abort_we", mem_we, 1'b1);
            chk("abort_addr", mem_addr, 10 + j);
            ref_mem[10 + j] = ld_data;
            tick();
        end
        ld_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_oob = 1'b0;
        #1;
        chk("abort_ready", ld_ready, 1'b0);
        chk("abort_cpu_reset", cpu_reset, 1'b1);
        chk("abort_busy", busy, 1'b1);
        chk("abort_oob_clear", oob_err, 1'b0);
        tick();
        do_load(0, 0, 0);
        fetch(10, ref_mem[10]);
        fetch(11, ref_mem[11]);
        fetch(12, ref_mem[12]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
